// File: rtl/dcache_fill.sv
// dcache_fill: moves whole cache lines between the nibble-serial data cache and a nibble-wide memory port.
// Optional burst watchdog: define DCACHE_FILL_TIMEOUT_EN.
module dcache_fill #(
    parameter int LINE_LENGTH = 4,
    parameter int PA          = 22,
    localparam int NNIB = 2 * LINE_LENGTH,
    localparam int OW   = $clog2(LINE_LENGTH),
    localparam int LW   = PA - OW,
    localparam int IW   = $clog2(NNIB),
    localparam int CW   = $clog2(NNIB) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          push,
    input  logic          pull,
    input  logic [LW-1:0] tag,
    input  logic [LW-1:0] victim,
    input  logic [3:0]    dwrite,
    output logic          rstrobe_d,
    output logic          wstrobe_d,
    output logic [3:0]    dread,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [LW-1:0] mem_addr,
    output logic [3:0]    mem_wdata,
    input  logic [3:0]    mem_rdata,
    input  logic          mem_ack
);

    typedef enum logic [2:0] {
        IDLE,
        WB_GRAB,
        WB_SEND,
        GAP,
        FILL_RECV,
        FILL_PUT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] tag_q, tag_d;
    logic [LW-1:0] victim_q, victim_d;
    logic          pull_q, pull_d;

    logic          rstb_q, rstb_d;
    logic          wstb_q, wstb_d;
    logic [3:0]    dread_q, dread_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [LW-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]    mem_wdata_q, mem_wdata_d;

    // One line of nibbles; both directions stage through here.
    logic [3:0]    line_buf [NNIB];
    logic          buf_we;
    logic [IW-1:0] buf_waddr;
    logic [3:0]    buf_wdata;
    logic          last_nib;

`ifdef DCACHE_FILL_TIMEOUT_EN
    logic [7:0]    wdog_q, wdog_d;
    logic          err_q, err_d;
`endif

    assign last_nib = (cnt_q == CW'(NNIB - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tag_d     = tag_q;
        victim_d  = victim_q;
        pull_d    = pull_q;
        done_d    = 1'b0;
        buf_we    = 1'b0;
        buf_waddr = cnt_q[IW-1:0];
        buf_wdata = dwrite;

        case (state_q)
            IDLE: begin
                if (start && push) begin
                    victim_d = victim;
                    tag_d    = tag;
                    pull_d   = pull;
                    state_d  = WB_GRAB;
                    cnt_d    = '0;
                end else if (start && pull) begin
                    tag_d   = tag;
                    pull_d  = 1'b1;
                    state_d = FILL_RECV;
                    cnt_d   = '0;
                end
            end
            WB_GRAB: begin
                buf_we    = 1'b1;
                buf_wdata = dwrite;
                if (last_nib) begin
                    state_d = WB_SEND;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WB_SEND: begin
                if (mem_ack) begin
                    if (last_nib) begin
                        cnt_d = '0;
                        if (pull_q) begin
                            state_d = GAP;
                        end else begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            GAP: begin
                state_d = FILL_RECV;
                cnt_d   = '0;
            end
            FILL_RECV: begin
                if (mem_ack) begin
                    buf_we    = 1'b1;
                    buf_wdata = mem_rdata;
                    if (last_nib) begin
                        state_d = FILL_PUT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FILL_PUT: begin
                if (last_nib) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef DCACHE_FILL_TIMEOUT_EN
        // Counts stalled burst cycles; the burst is abandoned as the count reaches 255.
        err_d  = 1'b0;
        wdog_d = (mem_req_q && !mem_ack) ? wdog_q + 8'd1 : 8'd0;
        if (mem_req_q && !mem_ack && (wdog_q == 8'd254)) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
            wdog_d  = 8'd0;
        end
`endif

        // Outputs are registered, so they are derived from the state being entered.
        busy_d      = (state_d != IDLE);
        rstb_d      = (state_d == WB_GRAB);
        wstb_d      = (state_d == FILL_PUT);
        mem_req_d   = (state_d == WB_SEND) || (state_d == FILL_RECV);
        mem_we_d    = (state_d == WB_SEND);
        mem_addr_d  = (state_d == WB_SEND)   ? victim_d :
                      (state_d == FILL_RECV) ? tag_d    : '0;
        mem_wdata_d = (state_d == WB_SEND)  ? line_buf[cnt_d[IW-1:0]] : 4'h0;
        dread_d     = (state_d == FILL_PUT) ? line_buf[cnt_d[IW-1:0]] : 4'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tag_q       <= '0;
            victim_q    <= '0;
            pull_q      <= 1'b0;
            rstb_q      <= 1'b0;
            wstb_q      <= 1'b0;
            dread_q     <= 4'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 4'h0;
`ifdef DCACHE_FILL_TIMEOUT_EN
            wdog_q      <= 8'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            victim_q    <= victim_d;
            pull_q      <= pull_d;
            rstb_q      <= rstb_d;
            wstb_q      <= wstb_d;
            dread_q     <= dread_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef DCACHE_FILL_TIMEOUT_EN
            wdog_q      <= wdog_d;
            err_q       <= err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf[buf_waddr] <= buf_wdata;
        end
    end

    assign rstrobe_d = rstb_q;
    assign wstrobe_d = wstb_q;
    assign dread     = dread_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
`ifdef DCACHE_FILL_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_fill.sv
// Directed bench for dcache_fill: cache-side and memory-side models record every cycle, then each run is checked.
module tb_dcache_fill;

    localparam int LW = 20;

    logic          clk = 1'b0;
    logic          reset, start, push, pull;
    logic [LW-1:0] tag, victim;
    logic [3:0]    dwrite, mem_rdata;
    logic          mem_ack;
    logic          rstrobe_d, wstrobe_d, busy, done, err, mem_req, mem_we;
    logic [3:0]    dread, mem_wdata;
    logic [LW-1:0] mem_addr;

    dcache_fill #(.LINE_LENGTH(4), .PA(22)) dut (
        .clk(clk), .reset(reset), .start(start), .push(push), .pull(pull),
        .tag(tag), .victim(victim), .dwrite(dwrite),
        .rstrobe_d(rstrobe_d), .wstrobe_d(wstrobe_d), .dread(dread),
        .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [511:0]  req_v, rstb_v, wstb_v, done_v, busy_v, err_v;
    logic [3:0]    wr_data [8];
    logic [3:0]    put_data [8];
    int            wr_cnt, rd_cnt, put_n, rstb_n, addr_bad, cyc;
    logic [LW-1:0] wr_addr, rd_addr;
    int            start_again_cyc = -1;
    int            rst_cyc = -1;
    bit            ack_alt = 1'b0;
    bit            ack_off = 1'b0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic int first_hi(input logic [511:0] v);
        for (int i = 0; i < 512; i++) if (v[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int last_hi(input logic [511:0] v);
        for (int i = 511; i >= 0; i--) if (v[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_hi(input logic [511:0] v);
        int n = 0;
        for (int i = 0; i < 512; i++) if (v[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic logic [31:0] pack_put();
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = put_data[i];
        return r;
    endfunction

    function automatic logic [31:0] pack_wr();
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = wr_data[i];
        return r;
    endfunction

    // One clock: record this cycle's outputs, then drive the cache and memory sides for it.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        start = (cyc == start_again_cyc);
        reset = (cyc == rst_cyc);
        if (cyc < 512) begin
            req_v[cyc]  = mem_req;
            rstb_v[cyc] = rstrobe_d;
            wstb_v[cyc] = wstrobe_d;
            done_v[cyc] = done;
            busy_v[cyc] = busy;
            err_v[cyc]  = err;
        end
        if (rstrobe_d) begin
            dwrite = 4'hF - 4'(rstb_n);
            rstb_n++;
        end else begin
            dwrite = 4'h0;
        end
        if (wstrobe_d && put_n < 8) begin
            put_data[put_n] = dread;
            put_n++;
        end
        mem_ack   = ack_off ? 1'b0 : (ack_alt ? (cyc % 2 == 0) : 1'b1);
        mem_rdata = 4'h0;
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                if (wr_cnt < 8) wr_data[wr_cnt] = mem_wdata;
                if (wr_cnt == 0) wr_addr = mem_addr;
                else if (mem_addr !== wr_addr) addr_bad++;
                wr_cnt++;
            end else begin
                mem_rdata = 4'(rd_cnt + 1);
                if (rd_cnt == 0) rd_addr = mem_addr;
                else if (mem_addr !== rd_addr) addr_bad++;
                rd_cnt++;
            end
        end
    endtask

    task automatic run(input logic p_push, input logic p_pull,
                       input logic [LW-1:0] p_tag, input logic [LW-1:0] p_victim,
                       input int ncyc);
        req_v = '0; rstb_v = '0; wstb_v = '0; done_v = '0; busy_v = '0; err_v = '0;
        for (int i = 0; i < 8; i++) begin
            wr_data[i]  = 4'h0;
            put_data[i] = 4'h0;
        end
        wr_cnt = 0; rd_cnt = 0; put_n = 0; rstb_n = 0; addr_bad = 0; cyc = 0;
        wr_addr = '0; rd_addr = '0;
        push = p_push; pull = p_pull; tag = p_tag; victim = p_victim;
        start = 1'b1;
        repeat (ncyc) step();
        start = 1'b0; push = 1'b0; pull = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; push = 1'b0; pull = 1'b0;
        tag = '0; victim = '0; dwrite = 4'h0; mem_rdata = 4'h0; mem_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_strobes", {30'h0, rstrobe_d, wstrobe_d}, 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_done_err", {30'h0, done, err}, 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_dread", 32'(dread), 32'h0);
        chk("rst_mem_wdata", {27'h0, mem_we, mem_wdata}, 32'h0);
        reset = 1'b0;

        // Fill only
        run(1'b0, 1'b1, 20'h1A5, 20'h0, 24);
        chk("fill_req_first", first_hi(req_v), 1);
        chk("fill_req_last", last_hi(req_v), 8);
        chk("fill_req_count", count_hi(req_v), 8);
        chk("fill_rd_cnt", rd_cnt, 8);
        chk("fill_wr_cnt", wr_cnt, 0);
        chk("fill_rd_addr", 32'(rd_addr), 32'h1A5);
        chk("fill_addr_stable", addr_bad, 0);
        chk("fill_wstb_first", first_hi(wstb_v), 9);
        chk("fill_wstb_last", last_hi(wstb_v), 16);
        chk("fill_wstb_count", count_hi(wstb_v), 8);
        chk("fill_dread", pack_put(), 32'h87654321);
        chk("fill_done_cyc", first_hi(done_v), 17);
        chk("fill_done_count", count_hi(done_v), 1);
        chk("fill_busy_first", first_hi(busy_v), 1);
        chk("fill_busy_last", last_hi(busy_v), 17);
        chk("fill_busy_count", count_hi(busy_v), 17);
        chk("fill_rstb_count", count_hi(rstb_v), 0);
        chk("fill_err_count", count_hi(err_v), 0);

        // Push + pull
        run(1'b1, 1'b1, 20'h1A5, 20'h033, 40);
        chk("pp_rstb_first", first_hi(rstb_v), 1);
        chk("pp_rstb_count", count_hi(rstb_v), 8);
        chk("pp_rstb_last", last_hi(rstb_v), 8);
        chk("pp_wr_data", pack_wr(), 32'h89ABCDEF);
        chk("pp_wr_addr", 32'(wr_addr), 32'h033);
        chk("pp_wr_cnt", wr_cnt, 8);
        chk("pp_req_first", first_hi(req_v), 9);
        chk("pp_req_last", last_hi(req_v), 25);
        chk("pp_req_count", count_hi(req_v), 16);
        chk("pp_gap", {req_v[18], req_v[17], req_v[16]}, 32'h5);
        chk("pp_rd_addr", 32'(rd_addr), 32'h1A5);
        chk("pp_rd_cnt", rd_cnt, 8);
        chk("pp_addr_stable", addr_bad, 0);
        chk("pp_wstb_first", first_hi(wstb_v), 26);
        chk("pp_wstb_count", count_hi(wstb_v), 8);
        chk("pp_dread", pack_put(), 32'h87654321);
        chk("pp_done_cyc", first_hi(done_v), 34);
        chk("pp_done_count", count_hi(done_v), 1);
        chk("pp_busy_last", last_hi(busy_v), 34);
        chk("pp_busy_count", count_hi(busy_v), 34);

        // Fill with mem_ack low on alternate cycles
        ack_alt = 1'b1;
        run(1'b0, 1'b1, 20'h2C3, 20'h0, 32);
        ack_alt = 1'b0;
        chk("alt_req_first", first_hi(req_v), 1);
        chk("alt_req_last", last_hi(req_v), 16);
        chk("alt_rd_cnt", rd_cnt, 8);
        chk("alt_wstb_first", first_hi(wstb_v), 17);
        chk("alt_wstb_last", last_hi(wstb_v), 24);
        chk("alt_wstb_count", count_hi(wstb_v), 8);
        chk("alt_dread", pack_put(), 32'h87654321);
        chk("alt_done_cyc", first_hi(done_v), 25);

        // Second start pulse during the write burst
        start_again_cyc = 12;
        run(1'b1, 1'b1, 20'h1A5, 20'h033, 45);
        start_again_cyc = -1;
        chk("restart_done_count", count_hi(done_v), 1);
        chk("restart_done_cyc", first_hi(done_v), 34);
        chk("restart_wr_cnt", wr_cnt, 8);
        chk("restart_rd_cnt", rd_cnt, 8);
        chk("restart_busy_last", last_hi(busy_v), 34);

        // Reset during the 4th read-strobe cycle
        rst_cyc = 4;
        run(1'b1, 1'b1, 20'h1A5, 20'h033, 10);
        rst_cyc = -1;
        chk("mid_rst_rstb_before", 32'(rstb_v[4]), 32'h1);
        chk("mid_rst_after", {29'h0, rstb_v[5], busy_v[5], req_v[5]}, 32'h0);
        chk("mid_rst_rstb_count", count_hi(rstb_v), 4);
        chk("mid_rst_done_count", count_hi(done_v), 0);
        chk("mid_rst_req_count", count_hi(req_v), 0);

        // Fresh push+pull after the reset
        run(1'b1, 1'b1, 20'h0F0, 20'h055, 40);
        chk("post_rst_wr_data", pack_wr(), 32'h89ABCDEF);
        chk("post_rst_wr_addr", 32'(wr_addr), 32'h055);
        chk("post_rst_rd_addr", 32'(rd_addr), 32'h0F0);
        chk("post_rst_dread", pack_put(), 32'h87654321);
        chk("post_rst_done_cyc", first_hi(done_v), 34);

        // Push only: no fill, done right after the write burst
        run(1'b1, 1'b0, 20'h0, 20'h02A, 24);
        chk("push_rstb_count", count_hi(rstb_v), 8);
        chk("push_wr_cnt", wr_cnt, 8);
        chk("push_rd_cnt", rd_cnt, 0);
        chk("push_req_last", last_hi(req_v), 16);
        chk("push_wstb_count", count_hi(wstb_v), 0);
        chk("push_done_cyc", first_hi(done_v), 17);
        chk("push_done_count", count_hi(done_v), 1);

`ifdef DCACHE_FILL_TIMEOUT_EN
        // Memory never acknowledges: the burst is abandoned after 255 cycles
        ack_off = 1'b1;
        run(1'b0, 1'b1, 20'h0F0, 20'h0, 300);
        ack_off = 1'b0;
        chk("to_req_first", first_hi(req_v), 1);
        chk("to_req_count", count_hi(req_v), 255);
        chk("to_err_cyc", first_hi(err_v), 256);
        chk("to_err_count", count_hi(err_v), 1);
        chk("to_wstb_count", count_hi(wstb_v), 0);
        chk("to_done_count", count_hi(done_v), 0);
        chk("to_busy_last", last_hi(busy_v), 255);
`else
        chk("noto_err_count", count_hi(err_v), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_fill.md
# dcache_fill

Memory-side line transfer engine for the nibble-serial data cache. On a miss it sequences the cache's line traffic: it drains a dirty victim line out of the cache (read strobes), writes it to external memory, fetches the new line from memory, then loads it into the cache (write strobes). It sits between the data cache and a nibble-wide external memory port, and buffers a full line so that cache-side strobes are always contiguous regardless of memory wait states.

## Interface
Parameters:
- `LINE_LENGTH`, 4 — cache line length in bytes; `NNIB = 2*LINE_LENGTH` nibbles per line.
- `PA`, 22 — physical address width; line address is `[PA-1:$clog2(LINE_LENGTH)]`, width `LW`.

Ports:
- `clk`  in  1  — clock; single clock domain.
- `reset`  in  1  — synchronous, active-high.
- `start`  in  1  — miss service request, sampled only in IDLE.
- `push`  in  1  — victim line is dirty; write-back required.
- `pull`  in  1  — line fill required.
- `tag`  in  LW  — line address of the fill.
- `victim`  in  LW  — line address of the write-back.
- `dwrite`  in  4  — nibble from cache, valid in the same cycle as `rstrobe_d`.
- `rstrobe_d`  out  1  — cache read strobe (drain victim).
- `wstrobe_d`  out  1  — cache write strobe (load line).
- `dread`  out  4  — nibble to cache, valid with `wstrobe_d`.
- `busy`  out  1  — engine not IDLE.
- `done`  out  1  — one-cycle completion pulse.
- `err`  out  1  — one-cycle timeout pulse (only with the timeout macro).
- `mem_req`  out  1  — burst active.
- `mem_we`  out  1  — 1 = write burst, 0 = read burst.
- `mem_addr`  out  LW  — burst line address.
- `mem_wdata`  out  4  — write nibble.
- `mem_rdata`  in  4  — read nibble, valid with `mem_ack`.
- `mem_ack`  in  1  — one nibble transferred this cycle.

## Operation
- States: IDLE, WB_GRAB, WB_SEND, GAP, FILL_RECV, FILL_PUT, DONE.
- IDLE: if `start && push`, latch `victim` and `tag`, then go to WB_GRAB. If `start && pull && !push`, latch `tag`, then go to FILL_RECV. If `start` arrives with neither `push` nor `pull`, stay in IDLE. `start` is ignored while busy.
- WB_GRAB: `rstrobe_d` is high for exactly NNIB consecutive cycles. Cycle k stores `dwrite` into `buf[k]`, k = 0..NNIB-1. The cache's offset counter requires an unbroken strobe run.
- WB_SEND: `mem_req=1`, `mem_we=1`, `mem_addr=victim`, `mem_wdata=buf[n]`. The index n advances on each `mem_ack`. After the NNIB-th ack: go to GAP if `pull` was latched, otherwise to DONE.
- GAP: one cycle with `mem_req=0`, then FILL_RECV.
- FILL_RECV: `mem_req=1`, `mem_we=0`, `mem_addr=tag`. Each `mem_ack` stores `mem_rdata` into `buf[n]`. After the NNIB-th ack, go to FILL_PUT.
- FILL_PUT: `wstrobe_d` is high for NNIB consecutive cycles, with `dread=buf[k]` in cycle k. Then go to DONE.
- DONE: `done=1` for one cycle, then IDLE.
- Nibble order is always 0 first, NNIB-1 last, in both directions.
- `mem_ack` is ignored while `mem_req=0`. The nibble counter is `$clog2(NNIB)+1` bits wide and is cleared on every state entry.
- `mem_req` always drops for at least one cycle between bursts and after the final burst.

## Timing
- All outputs are registered. Reset value of every output is 0; `mem_addr` and `dread` are also 0. State is IDLE and counters are 0.
- Reset mid-operation: in the cycle after the reset edge, all strobes and `mem_req` are low and state is IDLE. Buffer contents are don't-care.
- Cycle numbers below are counted from the edge that samples `start`, with `mem_ack` tied high.
- Fill only: `mem_req` in cycles 1–8, `wstrobe_d` in cycles 9–16, `done` in cycle 17.
- Push+pull:
  - `rstrobe_d` in cycles 1–8.
  - Write burst in cycles 9–16.
  - GAP in cycle 17.
  - Read burst in cycles 18–25.
  - `wstrobe_d` in cycles 26–33.
  - `done` in cycle 34.
- Each `mem_ack` wait cycle adds exactly one cycle of latency. Cache-side strobe runs are never stretched.
- `busy` is high from cycle 1 through the `done` cycle inclusive.

## Configuration
- `DCACHE_FILL_TIMEOUT_EN` defined:
  - An 8-bit watchdog clears on each `mem_ack` and on burst start.
  - If it reaches 255 while `mem_req=1`, the burst is abandoned: `mem_req` drops, `err` pulses for one cycle, and the next state is IDLE.
  - No strobes and no `done` are issued for the abandoned transfer.
- `DCACHE_FILL_TIMEOUT_EN` undefined: no watchdog; bursts wait indefinitely; `err` is tied to 0.

## Test plan
- Fill only, `tag=0x1A5`, `mem_ack` always high, memory nibbles 1..8 → `mem_addr=0x1A5`, `mem_we=0`; `wstrobe_d` for 8 consecutive cycles with `dread` = 1,2,…,8; `done` in cycle 17.
- Push+pull, `victim=0x033`, `tag=0x1A5`, cache drives `dwrite` = F,E,…,8 → write burst to 0x033 carries F..8 in order; one-cycle `mem_req` gap; read burst from 0x1A5; `done` in cycle 34.
- Fill with `mem_ack` low on alternate cycles → read burst takes 16 cycles; `wstrobe_d` is still 8 consecutive cycles with correct data.
- `start` pulsed again during WB_SEND → ignored; exactly one `done`.
- Reset asserted during the 4th `rstrobe_d` cycle → next cycle: `rstrobe_d=0`, `busy=0`, `mem_req=0`; a fresh `start` then runs normally.
- With `DCACHE_FILL_TIMEOUT_EN`, `mem_ack` held low → `err` pulses after 255 cycles of `mem_req`, then IDLE, with no `wstrobe_d` and no `done`.
